// File: rtl/uart_tx.sv
// UART transmitter: one frame per accepted request, made of a start bit (0),
// 8 data bits LSB first, one parity bit (odd or even) and one stop bit (1).
// Every frame bit lasts CLK_FREQ/BAUD_RATE clock cycles, truncated.
module uart_tx #(
  parameter int CLK_FREQ    = 100000000,
  parameter int BAUD_RATE   = 19200,
  parameter int PARITY_MODE = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       send,
  input  logic [7:0] din,
  output logic       tx_out,
  output logic       busy,
  output logic       done
);

  localparam int BAUD_CYCLES = CLK_FREQ / BAUD_RATE;
  localparam int CNT_W       = (BAUD_CYCLES > 1) ? $clog2(BAUD_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BAUD_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [2:0]       idx, idx_n;
  logic [7:0]       shreg, shreg_n;
  logic             tx_n, busy_n, done_n;
  logic             bit_end;

  // Parity is always taken from the latched byte so that din may change
  // freely while a frame is on the line.
  function automatic logic parity_bit(input logic [7:0] b);
    if (PARITY_MODE == 1) return ~^b;
    else                  return ^b;
  endfunction

  // Next-state logic; outputs are derived from the next state so that
  // tx_out, busy and done come straight out of flops.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    idx_n   = idx;
    shreg_n = shreg;
    bit_end = (cnt == CNT_LAST);

    case (state)
      IDLE: begin
        if (send) begin
          state_n = START;
          cnt_n   = '0;
          idx_n   = '0;
          shreg_n = din;
        end
      end
      START: begin
        if (bit_end) begin
          state_n = DATA;
          cnt_n   = '0;
          idx_n   = '0;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      DATA: begin
        if (bit_end) begin
          cnt_n = '0;
          if (idx == 3'd7) state_n = PARITY;
          else             idx_n   = idx + 3'd1;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      PARITY: begin
        if (bit_end) begin
          state_n = STOP;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      STOP: begin
        if (bit_end) begin
          state_n = IDLE;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
        idx_n   = '0;
      end
    endcase

    case (state_n)
      START:   tx_n = 1'b0;
      DATA:    tx_n = shreg_n[idx_n];
      PARITY:  tx_n = parity_bit(shreg_n);
      default: tx_n = 1'b1;
    endcase

    busy_n = (state_n != IDLE);
    done_n = (state_n == STOP) && (cnt_n == CNT_LAST);
  end

  // Control state and registered line outputs; reset aborts any frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      idx    <= '0;
      tx_out <= 1'b1;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      state  <= state_n;
      cnt    <= cnt_n;
      idx    <= idx_n;
      tx_out <= tx_n;
      busy   <= busy_n;
      done   <= done_n;
    end
  end

  // Data shift register: only meaningful after a byte is accepted.
  always_ff @(posedge clk) begin
    shreg <= shreg_n;
  end

endmodule
